// File: rtl/rand_pos_gen.sv
// Generates NUM_POS random (x, y) positions that keep a per-axis minimum
// distance from each other and from two exclusion points.
module rand_pos_gen #(
  parameter int unsigned NUM_POS   = 9,
  parameter int unsigned COORD_W   = 10,
  parameter int unsigned X_RANGE   = 320,
  parameter int unsigned Y_RANGE   = 180,
  parameter int unsigned MIN_DIST  = 32,
  parameter int unsigned MAX_TRIES = 64,
  parameter logic [15:0] SEED_X    = 16'h2019,
  parameter logic [15:0] SEED_Y    = 16'h1926
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_start,
  input  logic [COORD_W-1:0]         i_excl0_x,
  input  logic [COORD_W-1:0]         i_excl0_y,
  input  logic [COORD_W-1:0]         i_excl1_x,
  input  logic [COORD_W-1:0]         i_excl1_y,
  output logic [NUM_POS*COORD_W-1:0] o_pos_x,
  output logic [NUM_POS*COORD_W-1:0] o_pos_y,
  output logic [NUM_POS-1:0]         o_valid,
  output logic [3:0]                 o_count,
  output logic                       o_busy,
  output logic                       o_done,
  output logic                       o_data_ready,
  output logic                       o_fail
);

  localparam int unsigned IDX_W  = 5;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned TRY_W  = $clog2(MAX_TRIES + 1);
  localparam int unsigned DIST_W = COORD_W + 1;
  localparam logic [15:0] POLY   = 16'hB400;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAW,
    S_CHECK,
    S_COMMIT,
    S_DONE
  } state_e;

  function automatic logic [15:0] lfsr_step(input logic [15:0] r);
    return (r >> 1) ^ (r[0] ? POLY : 16'h0000);
  endfunction

  state_e               state_q, state_d;
  logic [15:0]          seed_cnt_q, seed_cnt_d;
  logic [15:0]          lfsr_x_q, lfsr_x_d, lfsr_y_q, lfsr_y_d;
  logic [COORD_W-1:0]   cx_q, cx_d, cy_q, cy_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [CNT_W-1:0]     slot_q, slot_d;
  logic [TRY_W-1:0]     tries_q, tries_d;
  logic [COORD_W-1:0]   e0x_q, e0x_d, e0y_q, e0y_d, e1x_q, e1x_d, e1y_q, e1y_d;
  logic [COORD_W-1:0]   pos_x_q [NUM_POS];
  logic [COORD_W-1:0]   pos_x_d [NUM_POS];
  logic [COORD_W-1:0]   pos_y_q [NUM_POS];
  logic [COORD_W-1:0]   pos_y_d [NUM_POS];
  logic [NUM_POS-1:0]   valid_q, valid_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 busy_q, busy_d, done_q, done_d, ready_q, ready_d, fail_q, fail_d;

  logic [COORD_W-1:0]   px_c, py_c;
  logic [DIST_W-1:0]    ax_c, bx_c, ay_c, by_c, dx_c, dy_c;
  logic                 conflict_c;
  logic [15:0]          sx_c, sy_c;

  // Point under test for the current check index, and its per-axis distance.
  always_comb begin
    px_c = e0x_q;
    py_c = e0y_q;
    if (idx_q == IDX_W'(1)) begin
      px_c = e1x_q;
      py_c = e1y_q;
    end
    for (int k = 0; k < int'(NUM_POS); k++) begin
      if (idx_q == IDX_W'(k + 2)) begin
        px_c = pos_x_q[k];
        py_c = pos_y_q[k];
      end
    end
    ax_c = DIST_W'(cx_q);
    bx_c = DIST_W'(px_c);
    ay_c = DIST_W'(cy_q);
    by_c = DIST_W'(py_c);
    dx_c = (ax_c >= bx_c) ? (ax_c - bx_c) : (bx_c - ax_c);
    dy_c = (ay_c >= by_c) ? (ay_c - by_c) : (by_c - ay_c);
    conflict_c = (32'(dx_c) < MIN_DIST) && (32'(dy_c) < MIN_DIST);
    sx_c = lfsr_x_q ^ seed_cnt_q;
    sy_c = lfsr_y_q ^ seed_cnt_q;
  end

  // Next-state and output logic.
  always_comb begin
    state_d    = state_q;
    seed_cnt_d = seed_cnt_q + 16'd1;
    lfsr_x_d   = lfsr_x_q;
    lfsr_y_d   = lfsr_y_q;
    cx_d       = cx_q;
    cy_d       = cy_q;
    idx_d      = idx_q;
    slot_d     = slot_q;
    tries_d    = tries_q;
    e0x_d      = e0x_q;
    e0y_d      = e0y_q;
    e1x_d      = e1x_q;
    e1y_d      = e1y_q;
    pos_x_d    = pos_x_q;
    pos_y_d    = pos_y_q;
    valid_d    = valid_q;
    count_d    = count_q;
    fail_d     = fail_q;

    if (state_q == S_DRAW || state_q == S_CHECK || state_q == S_COMMIT) begin
      lfsr_x_d = lfsr_step(lfsr_x_q);
      lfsr_y_d = lfsr_step(lfsr_y_q);
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (i_start) begin
          state_d  = S_DRAW;
          valid_d  = '0;
          count_d  = '0;
          fail_d   = 1'b0;
          e0x_d    = i_excl0_x;
          e0y_d    = i_excl0_y;
          e1x_d    = i_excl1_x;
          e1y_d    = i_excl1_y;
          slot_d   = '0;
          tries_d  = '0;
          lfsr_x_d = (sx_c == 16'h0000) ? SEED_X : sx_c;
          lfsr_y_d = (sy_c == 16'h0000) ? SEED_Y : sy_c;
        end
      end
      S_DRAW: begin
        cx_d    = COORD_W'((32'(lfsr_x_q) * X_RANGE) >> 16);
        cy_d    = COORD_W'((32'(lfsr_y_q) * Y_RANGE) >> 16);
        idx_d   = '0;
        state_d = S_CHECK;
      end
      S_CHECK: begin
        if (conflict_c) begin
          tries_d = tries_q + TRY_W'(1);
          if (tries_q == TRY_W'(MAX_TRIES - 1)) begin
            state_d = S_DONE;
            fail_d  = 1'b1;
          end else begin
            state_d = S_DRAW;
          end
        end else if (idx_q == IDX_W'(slot_q) + IDX_W'(1)) begin
          state_d = S_COMMIT;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      S_COMMIT: begin
        for (int k = 0; k < int'(NUM_POS); k++) begin
          if (slot_q == CNT_W'(k)) begin
            pos_x_d[k] = cx_q;
            pos_y_d[k] = cy_q;
            valid_d[k] = 1'b1;
          end
        end
        count_d = count_q + CNT_W'(1);
        tries_d = '0;
        slot_d  = slot_q + CNT_W'(1);
        state_d = (slot_q == CNT_W'(NUM_POS - 1)) ? S_DONE : S_DRAW;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d  = (state_d == S_DRAW) || (state_d == S_CHECK) || (state_d == S_COMMIT);
    done_d  = (state_d == S_DONE) && (state_q != S_DONE);
    ready_d = (state_d == S_DONE);
  end

  // State and output registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      seed_cnt_q <= '0;
      lfsr_x_q   <= SEED_X;
      lfsr_y_q   <= SEED_Y;
      cx_q       <= '0;
      cy_q       <= '0;
      idx_q      <= '0;
      slot_q     <= '0;
      tries_q    <= '0;
      e0x_q      <= '0;
      e0y_q      <= '0;
      e1x_q      <= '0;
      e1y_q      <= '0;
      for (int k = 0; k < int'(NUM_POS); k++) begin
        pos_x_q[k] <= '0;
        pos_y_q[k] <= '0;
      end
      valid_q    <= '0;
      count_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ready_q    <= 1'b0;
      fail_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      seed_cnt_q <= seed_cnt_d;
      lfsr_x_q   <= lfsr_x_d;
      lfsr_y_q   <= lfsr_y_d;
      cx_q       <= cx_d;
      cy_q       <= cy_d;
      idx_q      <= idx_d;
      slot_q     <= slot_d;
      tries_q    <= tries_d;
      e0x_q      <= e0x_d;
      e0y_q      <= e0y_d;
      e1x_q      <= e1x_d;
      e1y_q      <= e1y_d;
      pos_x_q    <= pos_x_d;
      pos_y_q    <= pos_y_d;
      valid_q    <= valid_d;
      count_q    <= count_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ready_q    <= ready_d;
      fail_q     <= fail_d;
    end
  end

  always_comb begin
    for (int k = 0; k < int'(NUM_POS); k++) begin
      o_pos_x[k*COORD_W +: COORD_W] = pos_x_q[k];
      o_pos_y[k*COORD_W +: COORD_W] = pos_y_q[k];
    end
  end

  assign o_valid      = valid_q;
  assign o_count      = count_q;
  assign o_busy       = busy_q;
  assign o_done       = done_q;
  assign o_data_ready = ready_q;
  assign o_fail       = fail_q;

endmodule
